// File: rtl/xcvr_reconfig_pkg.sv
// ---------------------------------------------------------------------------
// xcvr_reconfig_pkg
// Shared definitions for the transceiver reconfiguration AVMM initiator:
// command op encodings, FSM state encoding, reconfig bus widths and the
// masked-merge helper used by read-modify-write commands.
// ---------------------------------------------------------------------------
package xcvr_reconfig_pkg;

  localparam int RECONFIG_AW = 12;
  localparam int RECONFIG_DW = 32;

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_RMW = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_RSP   = 3'd4
  } state_e;

  // Bits set in mask take the new value, the rest keep the value read back.
  function automatic logic [RECONFIG_DW-1:0] rmw_merge(
    input logic [RECONFIG_DW-1:0] old_val,
    input logic [RECONFIG_DW-1:0] new_val,
    input logic [RECONFIG_DW-1:0] mask
  );
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/xcvr_reconfig_avmm_master.sv
// ---------------------------------------------------------------------------
// xcvr_reconfig_avmm_master
// Avalon-MM initiator for the multi-channel transceiver reconfiguration port.
// Takes one command at a time (read, write, masked read-modify-write), runs
// the AVMM cycle honouring waitrequest with a stall timeout, and returns a
// one-cycle response carrying read data and an error flag.
//
// Ports
//   i_reconfig_clk / i_reconfig_reset : clock, async active-high reset
//   i_cmd_valid / o_cmd_ready         : command handshake (ready = idle)
//   i_cmd_op/ch/ofs/wdata/mask        : command fields
//   o_rsp_valid/rdata/err             : one-cycle response
//   o_reconfig_*                      : AVMM initiator signals
//   i_reconfig_readdata/waitrequest   : AVMM slave return signals
// ---------------------------------------------------------------------------
module xcvr_reconfig_avmm_master
  import xcvr_reconfig_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int OFS_AW      = 10,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   i_reconfig_clk,
  input  logic                   i_reconfig_reset,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [1:0]             i_cmd_op,
  input  logic [1:0]             i_cmd_ch,
  input  logic [OFS_AW-1:0]      i_cmd_ofs,
  input  logic [RECONFIG_DW-1:0] i_cmd_wdata,
  input  logic [RECONFIG_DW-1:0] i_cmd_mask,
  output logic                   o_rsp_valid,
  output logic [RECONFIG_DW-1:0] o_rsp_rdata,
  output logic                   o_rsp_err,
  output logic                   o_reconfig_read,
  output logic                   o_reconfig_write,
  output logic [RECONFIG_AW-1:0] o_reconfig_address,
  output logic [RECONFIG_DW-1:0] o_reconfig_writedata,
  input  logic [RECONFIG_DW-1:0] i_reconfig_readdata,
  input  logic                   i_reconfig_waitrequest
);

  localparam int              CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e                 r_state, w_state_nxt;
  op_e                    r_op, w_op_nxt;
  logic [RECONFIG_AW-1:0] r_addr, w_addr_nxt;
  logic [RECONFIG_DW-1:0] r_wdata, w_wdata_nxt;
  logic [RECONFIG_DW-1:0] r_mask, w_mask_nxt;
  logic [RECONFIG_DW-1:0] r_rdata, w_rdata_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_cmd_ready, w_cmd_ready_nxt;
  logic                   r_read, w_read_nxt;
  logic                   r_write, w_write_nxt;
  logic                   r_rsp_valid, w_rsp_valid_nxt;
  logic                   r_rsp_err, w_rsp_err_nxt;
  logic [RECONFIG_DW-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                   w_legal;
  logic                   w_expired;

  assign w_legal   = (i_cmd_op != OP_RSV) && (32'(i_cmd_ch) < 32'(CH_NUM));
  assign w_expired = (r_cnt == CNT_LAST);

  // FSM state register
  always_ff @(posedge i_reconfig_clk or posedge i_reconfig_reset) begin
    if (i_reconfig_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode; all outputs are registered below
  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_mask_nxt      = r_mask;
    w_rdata_nxt     = r_rdata;
    w_cnt_nxt       = r_cnt;
    w_cmd_ready_nxt = r_cmd_ready;
    w_read_nxt      = r_read;
    w_write_nxt     = r_write;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = {RECONFIG_DW{1'b0}};

    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid && r_cmd_ready) begin
          w_cmd_ready_nxt = 1'b0;
          w_op_nxt        = op_e'(i_cmd_op);
          w_addr_nxt      = {i_cmd_ch, i_cmd_ofs};
          w_wdata_nxt     = i_cmd_wdata;
          w_mask_nxt      = i_cmd_mask;
          w_rdata_nxt     = {RECONFIG_DW{1'b0}};
          w_cnt_nxt       = {CNT_W{1'b0}};
          if (!w_legal) begin
            // RSP entered with no pulse pending: it emits the error pulse one cycle later
            w_state_nxt = S_RSP;
          end else if (i_cmd_op == OP_WR) begin
            w_state_nxt = S_WR;
            w_write_nxt = 1'b1;
          end else begin
            w_state_nxt = S_RD;
            w_read_nxt  = 1'b1;
          end
        end else begin
          w_cmd_ready_nxt = 1'b1;
        end
      end

      S_RD: begin
        if (!i_reconfig_waitrequest) begin
          w_read_nxt  = 1'b0;
          w_rdata_nxt = i_reconfig_readdata;
          if (r_op == OP_RMW) begin
            w_state_nxt = S_MERGE;
          end else begin
            w_state_nxt     = S_RSP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = i_reconfig_readdata;
          end
        end else if (w_expired) begin
          // Timed-out read returns zero data; an RMW never reaches the write phase
          w_read_nxt      = 1'b0;
          w_state_nxt     = S_RSP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_MERGE: begin
        w_wdata_nxt = rmw_merge(r_rdata, r_wdata, r_mask);
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_write_nxt = 1'b1;
        w_state_nxt = S_WR;
      end

      S_WR: begin
        if (!i_reconfig_waitrequest) begin
          w_write_nxt     = 1'b0;
          w_state_nxt     = S_RSP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_rdata;
        end else if (w_expired) begin
          w_write_nxt     = 1'b0;
          w_state_nxt     = S_RSP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = r_rdata;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_RSP: begin
        if (!r_rsp_valid) begin
          // Only an illegal command arrives here without a pulse already issued
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
        end else begin
          w_state_nxt     = S_IDLE;
          w_cmd_ready_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_read_nxt  = 1'b0;
        w_write_nxt = 1'b0;
      end
    endcase
  end

  // Command context, timeout counter and registered outputs
  always_ff @(posedge i_reconfig_clk or posedge i_reconfig_reset) begin
    if (i_reconfig_reset) begin
      r_op        <= OP_RD;
      r_addr      <= {RECONFIG_AW{1'b0}};
      r_wdata     <= {RECONFIG_DW{1'b0}};
      r_mask      <= {RECONFIG_DW{1'b0}};
      r_rdata     <= {RECONFIG_DW{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_cmd_ready <= 1'b0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= {RECONFIG_DW{1'b0}};
    end else begin
      r_op        <= w_op_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_mask      <= w_mask_nxt;
      r_rdata     <= w_rdata_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_read      <= w_read_nxt;
      r_write     <= w_write_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  assign o_cmd_ready          = r_cmd_ready;
  assign o_reconfig_read      = r_read;
  assign o_reconfig_write     = r_write;
  assign o_reconfig_address   = r_addr;
  assign o_reconfig_writedata = r_wdata;
  assign o_rsp_valid          = r_rsp_valid;
  assign o_rsp_err            = r_rsp_err;
  assign o_rsp_rdata          = r_rsp_rdata;

endmodule

// File: tb/tb_xcvr_reconfig_avmm_master.sv
// ---------------------------------------------------------------------------
// tb_xcvr_reconfig_avmm_master
// Directed and randomized transactions against a transaction-level model of
// the reconfig initiator: the bench plays the AVMM slave (programmable
// waitrequest stall per phase) and predicts address, write data, phase
// lengths, response latency, read data and error per command.
// ---------------------------------------------------------------------------
module tb_xcvr_reconfig_avmm_master;
  import xcvr_reconfig_pkg::*;

  localparam int CH_NUM = 3;
  localparam int OFS_AW = 10;
  localparam int TMO    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [1:0]  cmd_ch = 2'b00;
  logic [9:0]  cmd_ofs = 10'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic [31:0] cmd_mask = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rd, wr;
  logic [11:0] addr;
  logic [31:0] wdata_bus;
  logic [31:0] rdata_bus = 32'd0;
  logic        waitreq = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xcvr_reconfig_avmm_master #(
    .CH_NUM(CH_NUM), .OFS_AW(OFS_AW), .TIMEOUT_CYC(TMO)
  ) dut (
    .i_reconfig_clk(clk), .i_reconfig_reset(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_ch(cmd_ch), .i_cmd_ofs(cmd_ofs),
    .i_cmd_wdata(cmd_wdata), .i_cmd_mask(cmd_mask),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_reconfig_read(rd), .o_reconfig_write(wr),
    .o_reconfig_address(addr), .o_reconfig_writedata(wdata_bus),
    .i_reconfig_readdata(rdata_bus), .i_reconfig_waitrequest(waitreq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete command: model prediction, slave emulation, checks.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] ch, input logic [9:0] ofs,
                         input logic [31:0] wd, input logic [31:0] mk, input logic [31:0] rdv,
                         input int rs, input int ws, input bit junk);
    bit legal, do_rd, rd_to, do_wr, wr_to, e_err;
    int e_rdc, e_wrc, e_first_wr, e_lat;
    logic [11:0] e_addr;
    logic [31:0] e_wdata, e_rdata;
    int c, rsp_c, rdc, wrc, first_rd, first_wr, jr, jw, w;
    bit both, addr_bad, wd_bad, ready_bad;
    logic [31:0] got_rdata;
    logic got_err;

    // --- reference model ---
    legal  = (op != 2'b11) && (int'(ch) < CH_NUM);
    do_rd  = legal && (op == 2'b00 || op == 2'b10);
    rd_to  = do_rd && (rs >= TMO);
    do_wr  = legal && (op == 2'b01 || (op == 2'b10 && !rd_to));
    wr_to  = do_wr && (ws >= TMO);
    e_err  = !legal || rd_to || wr_to;
    e_rdc  = do_rd ? ((rs >= TMO) ? TMO : rs + 1) : 0;
    e_wrc  = do_wr ? ((ws >= TMO) ? TMO : ws + 1) : 0;
    e_first_wr = !do_wr ? -1 : (op == 2'b01) ? 1 : e_rdc + 2;
    if (!legal)                  e_lat = 2;
    else if (op == 2'b10 && !rd_to) e_lat = e_rdc + e_wrc + 2;
    else if (do_rd)              e_lat = e_rdc + 1;
    else                         e_lat = e_wrc + 1;
    e_addr = 12'(int'(ch) * (1 << OFS_AW) + int'(ofs));
    if (op == 2'b01) e_wdata = wd;
    else for (int b = 0; b < 32; b++) e_wdata[b] = mk[b] ? wd[b] : rdv[b];
    e_rdata = (do_rd && !rd_to) ? rdv : 32'd0;

    // --- wait for idle and issue ---
    w = 0;
    while (!cmd_ready && w < 50) begin tick(); w++; end
    chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_ch = ch; cmd_ofs = ofs; cmd_wdata = wd; cmd_mask = mk;
    tick();

    c = 1; rsp_c = -1; rdc = 0; wrc = 0; first_rd = -1; first_wr = -1; jr = 0; jw = 0;
    both = 0; addr_bad = 0; wd_bad = 0; ready_bad = 0; got_rdata = 32'd0; got_err = 1'b0;
    while (rsp_c < 0 && c < 4 * TMO + 20) begin
      if (rsp_valid) begin
        rsp_c = c; got_rdata = rsp_rdata; got_err = rsp_err; cmd_valid = 1'b0;
      end else if (junk) begin
        cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_ch = 2'($urandom);
        cmd_ofs = 10'($urandom); cmd_wdata = $urandom; cmd_mask = $urandom;
      end else begin
        cmd_valid = 1'b0;
      end
      if (cmd_ready) ready_bad = 1;
      if (rd && wr) both = 1;
      if (rd) begin
        rdc++; jr++;
        if (first_rd < 0) first_rd = c;
        if (addr !== e_addr) addr_bad = 1;
        waitreq   = (jr <= rs);
        rdata_bus = waitreq ? $urandom : rdv;
      end else begin
        jr = 0;
      end
      if (wr) begin
        wrc++; jw++;
        if (first_wr < 0) first_wr = c;
        if (addr !== e_addr) addr_bad = 1;
        if (wdata_bus !== e_wdata) wd_bad = 1;
        waitreq = (jw <= ws);
      end else begin
        jw = 0;
      end
      if (!rd && !wr) begin
        waitreq = 1'($urandom); rdata_bus = $urandom;
      end
      if (rsp_c < 0) begin tick(); c++; end
    end

    chk("rsp_seen", {31'd0, rsp_c >= 0}, 32'd1);
    chk("rsp_latency", rsp_c, e_lat);
    chk("rsp_rdata", got_rdata, e_rdata);
    chk("rsp_err", {31'd0, got_err}, {31'd0, e_err});
    chk("read_cycles", rdc, e_rdc);
    chk("write_cycles", wrc, e_wrc);
    chk("first_read", first_rd, do_rd ? 1 : -1);
    chk("first_write", first_wr, e_first_wr);
    chk("rd_wr_overlap", {31'd0, both}, 32'd0);
    chk("addr_stable", {31'd0, addr_bad}, 32'd0);
    chk("writedata", {31'd0, wd_bad}, 32'd0);
    chk("ready_busy", {31'd0, ready_bad}, 32'd0);
    waitreq = 1'b0;
    tick();
    chk("rsp_pulse_width", {31'd0, rsp_valid}, 32'd0);
    chk("ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    logic [1:0] r_op, r_ch;
    int rs, ws, sel;

    // Reset state
    tick(); tick();
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_read", {31'd0, rd}, 32'd0);
    chk("rst_write", {31'd0, wr}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_addr", {20'd0, addr}, 32'd0);
    chk("rst_wdata", wdata_bus, 32'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);

    // 1 write, no stall
    run_cmd(2'b01, 2'd2, 10'h105, 32'hA5A5_0001, 32'h0, 32'h0, 0, 0, 0);
    // 2 read stalled 5 cycles
    run_cmd(2'b00, 2'd0, 10'h3FF, 32'h0, 32'h0, 32'h1234_5678, 5, 0, 0);
    // 3 RMW merge
    run_cmd(2'b10, 2'd1, 10'h010, 32'h0000_00FF, 32'h0000_F0FF, 32'hFFFF_0000, 0, 0, 0);
    // 4 write stuck in waitrequest
    run_cmd(2'b01, 2'd0, 10'h001, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, TMO + 5, 0);
    // 5 reserved op, then out-of-range channel
    run_cmd(2'b11, 2'd0, 10'h020, 32'h1, 32'h1, 32'h0, 0, 0, 1);
    run_cmd(2'b00, 2'd3, 10'h020, 32'h1, 32'h1, 32'h5, 0, 0, 0);
    // boundaries: last-chance completion and read timeout inside RMW
    run_cmd(2'b00, 2'd1, 10'h2AA, 32'h0, 32'h0, 32'hCAFE_F00D, TMO - 1, 0, 0);
    run_cmd(2'b10, 2'd2, 10'h155, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1111_2222, TMO, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      r_op = 2'($urandom_range(0, 3));
      r_ch = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      rs = (sel < 7) ? $urandom_range(0, 3) : (sel == 7) ? TMO - 1 : (sel == 8) ? TMO : 0;
      sel = $urandom_range(0, 9);
      ws = (sel < 7) ? $urandom_range(0, 3) : (sel == 7) ? TMO - 1 : (sel == 8) ? TMO : 0;
      run_cmd(r_op, r_ch, 10'($urandom), $urandom, $urandom, $urandom, rs, ws,
              1'($urandom_range(0, 1)));
    end

    // 6 reset during a stalled read
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_ch = 2'd1; cmd_ofs = 10'h0AB;
    tick();
    cmd_valid = 1'b0; waitreq = 1'b1;
    tick(); tick(); tick();
    chk("stall_read_high", {31'd0, rd}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_read_drop", {31'd0, rd}, 32'd0);
    chk("async_ready_low", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("reset_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk); rst = 1'b0; waitreq = 1'b0;
    tick();
    chk("post_reset_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("post_reset_ready", {31'd0, cmd_ready}, 32'd1);
    run_cmd(2'b10, 2'd0, 10'h077, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h1357_9BDF, 2, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
